// File: rtl/piece_ctr_if.sv
// piece_ctr_if: key/flag inputs and piece-state outputs of the falling-piece
// controller.
//   master : drives keys and board flags, observes the piece (board/top side)
//   slave  : piece_ctr itself
//   key_left/key_right/key_rot  active-high levels, edge-detected in the slave
//   move_reset  cell below piece occupied; nl/nr left/right neighbour occupied
//   lflag       rotation permitted
//   xadd/yadd   piece origin in pixels (multiples of 40)
//   x0..y3      cell offsets from origin, in cells
//   shape/direction/spawn/game_over  piece identity and status
interface piece_ctr_if;
  logic       key_left, key_right, key_rot;
  logic       move_reset, nl, nr, lflag;
  logic [9:0] xadd, yadd;
  logic [1:0] x0, y0, x1, y1, x2, y2, x3, y3;
  logic [2:0] shape;
  logic [1:0] direction;
  logic       spawn, game_over;

  modport master (
    output key_left, key_right, key_rot, move_reset, nl, nr, lflag,
    input  xadd, yadd, x0, y0, x1, y1, x2, y2, x3, y3,
           shape, direction, spawn, game_over
  );

  modport slave (
    input  key_left, key_right, key_rot, move_reset, nl, nr, lflag,
    output xadd, yadd, x0, y0, x1, y1, x2, y2, x3, y3,
           shape, direction, spawn, game_over
  );
endinterface

// File: rtl/piece_ctr.sv
// piece_ctr: active-tetromino controller. Applies gravity, key moves and
// rotation, holds the landed piece while the board locks it, then spawns the
// next piece chosen by an 8-bit LFSR.
//   VGA_CLK_n  system clock (rising edge)
//   iRST_n     asynchronous active-low reset
//   bus        piece_ctr_if.slave (keys, board flags, piece state)
module piece_ctr #(
  parameter int DROP_TICKS  = 12_500_000,
  parameter int LOCK_CYCLES = 20_000_000,
  parameter int SETTLE      = 2,
  parameter int SPAWN_COL   = 4
) (
  input  logic          VGA_CLK_n,
  input  logic          iRST_n,
  piece_ctr_if.slave    bus
);

  localparam int CMAX = (DROP_TICKS > LOCK_CYCLES) ? DROP_TICKS : LOCK_CYCLES;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] DROP_LAST = CW'(DROP_TICKS - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [9:0]    X_SPAWN   = 10'(SPAWN_COL * 40);
  localparam logic [9:0]    STEP      = 10'd40;
  localparam logic [9:0]    Y_FLOOR   = 10'd440;

  typedef enum logic [1:0] {SPAWN, FALL, LOCK, OVER} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;      // gravity count in FALL, hold count in LOCK
  logic [SW-1:0]   settle;   // key lockout after an accepted move/rotate
  logic [7:0]      lfsr;
  logic [2:0]      key_s, key_d, rise;   // {rot, right, left}
  logic [9:0]      xadd, yadd;
  logic [2:0]      shape;
  logic [1:0]      direction;
  logic            spawn, game_over;
  logic [15:0]     offs;     // {x0,y0,x1,y1,x2,y2,x3,y3}
  logic [1:0]      min_a, min_b, min_x;
  logic            tick, landed, idle_keys;
  logic            do_drop, do_rot, do_left, do_right, any_key;

  assign rise = key_s & ~key_d;

  // state register
  always_ff @(posedge VGA_CLK_n or negedge iRST_n)
    if (!iRST_n) state <= SPAWN;
    else         state <= state_nx;

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      SPAWN:   state_nx = FALL;
      FALL:    if (tick && landed) state_nx = (yadd != 10'd0) ? LOCK : OVER;
      LOCK:    if (cnt == LOCK_LAST) state_nx = SPAWN;
      default: state_nx = OVER;
    endcase
  end

  // control strobes; gravity wins the cycle, then rotate > left > right.
  // Unused edges are lost because key_d catches up every clock.
  always_comb begin
    tick      = (state == FALL) && (cnt == DROP_LAST);
    landed    = bus.move_reset || (yadd >= Y_FLOOR);
    do_drop   = tick && !landed;
    idle_keys = (state == FALL) && !tick && (settle == '0);
    do_rot    = idle_keys && rise[2] && bus.lflag && !bus.move_reset;
    do_left   = idle_keys && !do_rot && rise[0] && !bus.nl &&
                ((xadd != 10'd0) || (min_x != 2'd0));
    do_right  = idle_keys && !do_rot && !do_left && rise[1] && !bus.nr;
    any_key   = do_rot || do_left || do_right;
  end

  // datapath
  always_ff @(posedge VGA_CLK_n or negedge iRST_n) begin
    if (!iRST_n) begin
      lfsr      <= 8'hA5;
      key_s     <= '0;
      key_d     <= '0;
      cnt       <= '0;
      settle    <= '0;
      xadd      <= X_SPAWN;
      yadd      <= '0;
      shape     <= '0;
      direction <= '0;
      spawn     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      key_s <= {bus.key_rot, bus.key_right, bus.key_left};
      key_d <= key_s;
      spawn <= (state == SPAWN);
      case (state)
        SPAWN: begin
          shape     <= 3'(lfsr % 8'd5);
          direction <= '0;
          xadd      <= X_SPAWN;
          yadd      <= '0;
          cnt       <= '0;
          settle    <= '0;
        end
        FALL: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (do_drop)  yadd      <= yadd + STEP;
          if (do_rot)   direction <= direction + 2'd1;
          if (do_left)  xadd      <= xadd - STEP;
          if (do_right) xadd      <= xadd + STEP;
          if (any_key)            settle <= SW'(SETTLE);
          else if (settle != '0)  settle <= settle - 1'b1;
          if (state_nx == OVER)   game_over <= 1'b1;
        end
        LOCK:    cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // cell offsets, combinational from registered shape/direction
  always_comb begin
    offs = {2'd0,2'd0, 2'd1,2'd0, 2'd0,2'd1, 2'd1,2'd1};  // square
    case (shape)
      3'd1: offs = direction[0] ? {2'd0,2'd0, 2'd0,2'd1, 2'd0,2'd2, 2'd0,2'd3}
                                : {2'd0,2'd0, 2'd1,2'd0, 2'd2,2'd0, 2'd3,2'd0};
      3'd2: case (direction)
        2'd0: offs = {2'd0,2'd0, 2'd0,2'd1, 2'd0,2'd2, 2'd1,2'd2};
        2'd1: offs = {2'd0,2'd0, 2'd1,2'd0, 2'd2,2'd0, 2'd0,2'd1};
        2'd2: offs = {2'd0,2'd0, 2'd1,2'd0, 2'd1,2'd1, 2'd1,2'd2};
        default: offs = {2'd2,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1};
      endcase
      3'd3: case (direction)
        2'd0: offs = {2'd0,2'd0, 2'd1,2'd0, 2'd2,2'd0, 2'd1,2'd1};
        2'd1: offs = {2'd1,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd1,2'd2};
        2'd2: offs = {2'd1,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1};
        default: offs = {2'd0,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd0,2'd2};
      endcase
      3'd4: offs = direction[0] ? {2'd1,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd0,2'd2}
                                : {2'd0,2'd0, 2'd1,2'd0, 2'd1,2'd1, 2'd2,2'd1};
      default: ;
    endcase
  end

  // leftmost occupied cell column relative to origin, for the left-wall test
  assign min_a = (offs[15:14] < offs[11:10]) ? offs[15:14] : offs[11:10];
  assign min_b = (offs[7:6]   < offs[3:2])   ? offs[7:6]   : offs[3:2];
  assign min_x = (min_a < min_b) ? min_a : min_b;

  assign {bus.x0, bus.y0, bus.x1, bus.y1, bus.x2, bus.y2, bus.x3, bus.y3} = offs;
  assign bus.xadd      = xadd;
  assign bus.yadd      = yadd;
  assign bus.shape     = shape;
  assign bus.direction = direction;
  assign bus.spawn     = spawn;
  assign bus.game_over = game_over;

endmodule

// File: tb/tb_piece_ctr.sv
// tb_piece_ctr: directed bench for piece_ctr with DROP_TICKS=8,
// LOCK_CYCLES=16, SETTLE=2, SPAWN_COL=4. Inputs change and outputs are sampled
// on the falling clock edge. N<k> in comments is the falling edge after the
// k-th rising edge following reset release (the spawn edge is rising edge 1).
module tb_piece_ctr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piece_ctr_if bus ();

  piece_ctr #(.DROP_TICKS(8), .LOCK_CYCLES(16), .SETTLE(2), .SPAWN_COL(4)) dut (
    .VGA_CLK_n(clk),
    .iRST_n   (rst_n),
    .bus      (bus)
  );

  int ntot = 0;
  int npass = 0;

  // reference shape source: value consumed by the most recent edge is lf_prev
  logic [7:0] lf_m, lf_prev;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lf_m    <= 8'hA5;
      lf_prev <= 8'hA5;
    end else begin
      lf_prev <= lf_m;
      lf_m    <= {lf_m[6:0], ^(lf_m & 8'hB8)};
    end

  function automatic logic [15:0] pk(input int a, b, c, d, e, f, g, h);
    return {2'(a), 2'(b), 2'(c), 2'(d), 2'(e), 2'(f), 2'(g), 2'(h)};
  endfunction

  function automatic logic [15:0] exp_off(input logic [2:0] s, input logic [1:0] d);
    case (s)
      3'd1: return d[0] ? pk(0,0, 0,1, 0,2, 0,3) : pk(0,0, 1,0, 2,0, 3,0);
      3'd2: case (d)
              2'd0: return pk(0,0, 0,1, 0,2, 1,2);
              2'd1: return pk(0,0, 1,0, 2,0, 0,1);
              2'd2: return pk(0,0, 1,0, 1,1, 1,2);
              default: return pk(2,0, 0,1, 1,1, 2,1);
            endcase
      3'd3: case (d)
              2'd0: return pk(0,0, 1,0, 2,0, 1,1);
              2'd1: return pk(1,0, 0,1, 1,1, 1,2);
              2'd2: return pk(1,0, 0,1, 1,1, 2,1);
              default: return pk(0,0, 0,1, 1,1, 0,2);
            endcase
      3'd4: return d[0] ? pk(1,0, 0,1, 1,1, 0,2) : pk(0,0, 1,0, 1,1, 2,1);
      default: return pk(0,0, 1,0, 0,1, 1,1);
    endcase
  endfunction

  function automatic logic [15:0] got_off();
    return {bus.x0, bus.y0, bus.x1, bus.y1, bus.x2, bus.y2, bus.x3, bus.y3};
  endfunction

  task automatic clear_inputs();
    bus.key_left = 0; bus.key_right = 0; bus.key_rot = 0;
    bus.move_reset = 0; bus.nl = 0; bus.nr = 0; bus.lflag = 0;
  endtask

  // ends at N1 (spawn pulse visible)
  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // one-clock key pulse starting at N<k>; action lands on rising edge k+2;
  // returns at N<k+4> with the lockout expired
  task automatic pulse(input int k);
    case (k)
      0: bus.key_left = 1;
      1: bus.key_right = 1;
      default: bus.key_rot = 1;
    endcase
    @(negedge clk);
    bus.key_left = 0; bus.key_right = 0; bus.key_rot = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    ntot++; if (bus.xadd !== 10'd160) $display("FAIL rst_xadd got=%0d want=160", bus.xadd); else npass++;
    ntot++; if (bus.yadd !== 10'd0) $display("FAIL rst_yadd got=%0d want=0", bus.yadd); else npass++;
    ntot++; if (bus.shape !== 3'd0 || bus.direction !== 2'd0) $display("FAIL rst_shape_dir got=%0d/%0d want=0/0", bus.shape, bus.direction); else npass++;
    ntot++; if (bus.spawn !== 1'b0 || bus.game_over !== 1'b0) $display("FAIL rst_flags got=%b%b want=00", bus.spawn, bus.game_over); else npass++;
    ntot++; if (got_off() !== exp_off(3'd0, 2'd0)) $display("FAIL rst_offs got=%h want=%h", got_off(), exp_off(3'd0, 2'd0)); else npass++;
    rst_n = 1;
    @(negedge clk);
    ntot++; if (bus.spawn !== 1'b1) $display("FAIL spawn_pulse got=%b want=1", bus.spawn); else npass++;
    ntot++; if (bus.shape !== 3'(lf_prev % 8'd5)) $display("FAIL spawn_shape got=%0d want=%0d", bus.shape, lf_prev % 8'd5); else npass++;
    @(negedge clk);
    ntot++; if (bus.spawn !== 1'b0) $display("FAIL spawn_one_clk got=%b want=0", bus.spawn); else npass++;
  endtask

  task automatic test_gravity();
    do_reset();
    repeat (7) @(negedge clk);   // N8
    ntot++; if (bus.yadd !== 10'd0) $display("FAIL grav_early got=%0d want=0", bus.yadd); else npass++;
    @(negedge clk);              // N9
    ntot++; if (bus.yadd !== 10'd40) $display("FAIL grav_step got=%0d want=40", bus.yadd); else npass++;
    repeat (8) @(negedge clk);   // N17
    ntot++; if (bus.yadd !== 10'd80) $display("FAIL grav_step2 got=%0d want=80", bus.yadd); else npass++;
  endtask

  task automatic test_left();
    do_reset();                  // N1
    bus.key_left = 1; @(negedge clk); bus.key_left = 0; @(negedge clk);   // N3
    ntot++; if (bus.xadd !== 10'd120) $display("FAIL left_step got=%0d want=120", bus.xadd); else npass++;
    bus.key_left = 1; @(negedge clk); bus.key_left = 0; @(negedge clk);   // N5, edge hit lockout
    ntot++; if (bus.xadd !== 10'd120) $display("FAIL left_lockout got=%0d want=120", bus.xadd); else npass++;
    bus.key_left = 1; @(negedge clk); bus.key_left = 0; @(negedge clk);   // N7
    ntot++; if (bus.xadd !== 10'd80) $display("FAIL left_after_settle got=%0d want=80", bus.xadd); else npass++;
  endtask

  task automatic test_walls();
    do_reset();
    repeat (4) pulse(0);
    ntot++; if (bus.xadd !== 10'd0) $display("FAIL wall_reach got=%0d want=0", bus.xadd); else npass++;
    pulse(0);
    ntot++; if (bus.xadd !== 10'd0) $display("FAIL wall_left_block got=%0d want=0", bus.xadd); else npass++;
    bus.nr = 1; pulse(1);
    ntot++; if (bus.xadd !== 10'd0) $display("FAIL nr_block got=%0d want=0", bus.xadd); else npass++;
    bus.nr = 0; pulse(1);
    ntot++; if (bus.xadd !== 10'd40) $display("FAIL right_step got=%0d want=40", bus.xadd); else npass++;
    bus.nl = 1; pulse(0);        // ends N33
    bus.nl = 0;
    ntot++; if (bus.xadd !== 10'd40) $display("FAIL nl_block got=%0d want=40", bus.xadd); else npass++;
    ntot++; if (bus.yadd !== 10'd160) $display("FAIL keys_vs_grav got=%0d want=160", bus.yadd); else npass++;
  endtask

  task automatic test_coincide();
    do_reset();
    repeat (6) @(negedge clk);   // N7
    bus.key_left = 1; @(negedge clk); bus.key_left = 0; @(negedge clk);   // N9
    ntot++; if (bus.yadd !== 10'd40 || bus.xadd !== 10'd160) $display("FAIL coincide got=x%0d,y%0d want=x160,y40", bus.xadd, bus.yadd); else npass++;
    repeat (2) @(negedge clk);
    ntot++; if (bus.xadd !== 10'd160) $display("FAIL coincide_not_queued got=%0d want=160", bus.xadd); else npass++;
  endtask

  task automatic test_lock_rotate();
    logic [2:0] s;
    do_reset();
    repeat (40) @(negedge clk);  // N41
    ntot++; if (bus.yadd !== 10'd200) $display("FAIL pre_lock_y got=%0d want=200", bus.yadd); else npass++;
    bus.move_reset = 1;
    repeat (8) @(negedge clk);   // N49, LOCK entered
    bus.move_reset = 0;
    ntot++; if (bus.yadd !== 10'd200) $display("FAIL land_y got=%0d want=200", bus.yadd); else npass++;
    pulse(1);                    // ignored while locked, ends N53
    repeat (12) @(negedge clk);  // N65
    ntot++; if (bus.spawn !== 1'b0 || bus.yadd !== 10'd200 || bus.xadd !== 10'd160) $display("FAIL lock_frozen got=s%b,x%0d,y%0d want=s0,x160,y200", bus.spawn, bus.xadd, bus.yadd); else npass++;
    @(negedge clk);              // N66
    ntot++; if (bus.spawn !== 1'b1 || bus.yadd !== 10'd0 || bus.direction !== 2'd0) $display("FAIL respawn got=s%b,y%0d,d%0d want=s1,y0,d0", bus.spawn, bus.yadd, bus.direction); else npass++;
    ntot++; if (bus.shape !== 3'(lf_prev % 8'd5)) $display("FAIL respawn_shape got=%0d want=%0d", bus.shape, lf_prev % 8'd5); else npass++;
    s = 3'(lf_prev % 8'd5);
    bus.lflag = 1;
    for (int d = 1; d <= 4; d++) begin
      pulse(2);
      ntot++; if (bus.direction !== 2'(d)) $display("FAIL rot_dir got=%0d want=%0d", bus.direction, d % 4); else npass++;
      ntot++; if (got_off() !== exp_off(s, 2'(d))) $display("FAIL rot_offs got=%h want=%h", got_off(), exp_off(s, 2'(d))); else npass++;
    end
    bus.lflag = 0;
    pulse(2);
    ntot++; if (bus.direction !== 2'd0) $display("FAIL rot_denied got=%0d want=0", bus.direction); else npass++;
  endtask

  task automatic test_over_and_async();
    do_reset();
    bus.move_reset = 1;
    repeat (7) @(negedge clk);   // N8
    ntot++; if (bus.game_over !== 1'b0) $display("FAIL over_early got=%b want=0", bus.game_over); else npass++;
    @(negedge clk);              // N9
    ntot++; if (bus.game_over !== 1'b1 || bus.yadd !== 10'd0) $display("FAIL over_set got=g%b,y%0d want=g1,y0", bus.game_over, bus.yadd); else npass++;
    bus.move_reset = 0;
    pulse(0); pulse(1);
    repeat (10) @(negedge clk);
    ntot++; if (bus.game_over !== 1'b1 || bus.xadd !== 10'd160 || bus.yadd !== 10'd0 || bus.spawn !== 1'b0) $display("FAIL over_sticky got=g%b,x%0d,y%0d,s%b want=g1,x160,y0,s0", bus.game_over, bus.xadd, bus.yadd, bus.spawn); else npass++;
    #2 rst_n = 0;
    #1;
    ntot++; if (bus.game_over !== 1'b0) $display("FAIL over_cleared got=%b want=0", bus.game_over); else npass++;
    // mid-flight reset with a moved piece
    do_reset();
    pulse(0);
    ntot++; if (bus.xadd !== 10'd120) $display("FAIL pre_async_x got=%0d want=120", bus.xadd); else npass++;
    #2 rst_n = 0;
    #1;
    ntot++; if (bus.xadd !== 10'd160 || bus.yadd !== 10'd0 || bus.spawn !== 1'b0) $display("FAIL async_reset got=x%0d,y%0d,s%b want=x160,y0,s0", bus.xadd, bus.yadd, bus.spawn); else npass++;
    do_reset();
    ntot++; if (bus.shape !== 3'd0 || bus.spawn !== 1'b1) $display("FAIL reseed got=sh%0d,s%b want=sh0,s1", bus.shape, bus.spawn); else npass++;
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_left();
    test_walls();
    test_coincide();
    test_lock_rotate();
    test_over_and_async();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
